// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// pipe_hazard_ctrl
// ----------------
// Central pipeline sequencer for the 5-stage RV32 core. Produces the write
// enables and flush/bubble controls for the PC and the IF/ID, ID/EX and EX/MEM
// pipeline registers. It arbitrates between data-memory wait states, mul/div
// occupancy, EX-stage redirects, load-use hazards and instruction-memory wait
// states. It also keeps two performance counters.
//
// Ports:
//   i_clk, i_resetn            clock, asynchronous active-low reset
//   i_id_rs1/rs2, i_id_uses_*  source registers of the ID instruction and their use flags
//   i_ex_rd, i_ex_memread      destination register / load flag of the EX instruction
//   i_ex_redirect              taken branch or resolved jump in EX
//   i_ex_is_muldiv, i_md_done  mul/div instruction in EX; one-cycle result-valid pulse
//   i_imem_ready, i_dmem_ready fetch data valid; MEM access completes (1 when idle)
//   o_*_we, o_*_flush          register enables and NOP/bubble inserts
//   o_md_start                 one-cycle start pulse to the mul/div unit
//   o_stall_cnt                cycles with o_pc_we = 0 (wraps)
//   o_redir_cnt                accepted redirects (saturates at all-ones)

module pipe_hazard_ctrl #(
  parameter int CNT_W  = 32,
  parameter int RCNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic [4:0]        i_id_rs1,
  input  logic [4:0]        i_id_rs2,
  input  logic              i_id_uses_rs1,
  input  logic              i_id_uses_rs2,
  input  logic [4:0]        i_ex_rd,
  input  logic              i_ex_memread,
  input  logic              i_ex_redirect,
  input  logic              i_ex_is_muldiv,
  input  logic              i_md_done,
  input  logic              i_imem_ready,
  input  logic              i_dmem_ready,
  output logic              o_pc_we,
  output logic              o_ifid_we,
  output logic              o_ifid_flush,
  output logic              o_idex_we,
  output logic              o_idex_flush,
  output logic              o_exmem_we,
  output logic              o_exmem_flush,
  output logic              o_md_start,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [RCNT_W-1:0] o_redir_cnt
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   load_use;
  logic   redir_taken;

  // A load in EX whose destination is read by the ID instruction cannot be
  // forwarded yet. x0 is never a real dependency.
  assign load_use = i_ex_memread && (i_ex_rd != 5'd0) &&
                    ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                     (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));

  // State register. Reset abandons any mul/div in flight.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Priority arbitration. The first matching event owns the outputs. A data
  // memory wait freezes the whole pipeline, so anything pending in EX
  // (redirect, mul/div) is simply presented again once memory completes.
  always_comb begin
    o_pc_we       = 1'b1;
    o_ifid_we     = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_we     = 1'b1;
    o_idex_flush  = 1'b0;
    o_exmem_we    = 1'b1;
    o_exmem_flush = 1'b0;
    o_md_start    = 1'b0;
    redir_taken   = 1'b0;
    state_nxt     = state;

    if (!i_resetn) begin
      o_pc_we    = 1'b0;
      o_ifid_we  = 1'b0;
      o_idex_we  = 1'b0;
      o_exmem_we = 1'b0;
      state_nxt  = RUN;
    end else if (!i_dmem_ready) begin
      o_pc_we    = 1'b0;
      o_ifid_we  = 1'b0;
      o_idex_we  = 1'b0;
      o_exmem_we = 1'b0;
    end else if (state == MD_BUSY) begin
      if (!i_md_done) begin
        // Hold the front end; bubbles drain into MEM while the unit works.
        o_pc_we       = 1'b0;
        o_ifid_we     = 1'b0;
        o_idex_we     = 1'b0;
        o_exmem_flush = 1'b1;
      end else begin
        // Result is captured into EX/MEM with the default enables.
        state_nxt = RUN;
      end
    end else if (i_ex_is_muldiv) begin
      o_md_start    = 1'b1;
      o_pc_we       = 1'b0;
      o_ifid_we     = 1'b0;
      o_idex_we     = 1'b0;
      o_exmem_flush = 1'b1;
      state_nxt     = MD_BUSY;
    end else if (i_ex_redirect) begin
      // Younger instructions in IF/ID are on the wrong path; squash both.
      // The PC loads the target even if the current fetch is not ready.
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
      redir_taken  = 1'b1;
    end else if (load_use) begin
      o_pc_we      = 1'b0;
      o_ifid_we    = 1'b0;
      o_idex_flush = 1'b1;
    end else if (!i_imem_ready) begin
      o_pc_we      = 1'b0;
      o_ifid_flush = 1'b1;
    end
  end

  // Stall-cycle counter: counts every cycle the PC is held, wraps freely.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_stall_cnt <= '0;
    end else if (!o_pc_we) begin
      o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end

  // Redirect counter: counts only redirects that actually won arbitration,
  // and sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_redir_cnt <= '0;
    end else if (redir_taken && (o_redir_cnt != {RCNT_W{1'b1}})) begin
      o_redir_cnt <= o_redir_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// tb_pipe_hazard_ctrl
// -------------------
// Self-checking bench for pipe_hazard_ctrl. Each test task drives a short
// table of per-cycle input patterns, pushes the expected control vector
// {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush,
// md_start} into a scoreboard queue, and pops/compares it mid-cycle. Counter
// expectations are tracked from the expected vectors.

module tb_pipe_hazard_ctrl;

  localparam logic [7:0] DEF = 8'b1101_0100;
  localparam logic [7:0] LU  = 8'b0001_1100;
  localparam logic [7:0] RED = 8'b1111_1100;
  localparam logic [7:0] IMW = 8'b0111_0100;
  localparam logic [7:0] MDS = 8'b0000_0111;
  localparam logic [7:0] MDB = 8'b0000_0110;
  localparam logic [7:0] FRZ = 8'b0000_0000;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses1;
    logic       uses2;
    logic [4:0] rd;
    logic       memread;
    logic       redirect;
    logic       muldiv;
    logic       done;
    logic       imem;
    logic       dmem;
  } in_t;

  logic        i_clk;
  logic        i_resetn;
  logic [4:0]  i_id_rs1;
  logic [4:0]  i_id_rs2;
  logic        i_id_uses_rs1;
  logic        i_id_uses_rs2;
  logic [4:0]  i_ex_rd;
  logic        i_ex_memread;
  logic        i_ex_redirect;
  logic        i_ex_is_muldiv;
  logic        i_md_done;
  logic        i_imem_ready;
  logic        i_dmem_ready;
  logic        o_pc_we;
  logic        o_ifid_we;
  logic        o_ifid_flush;
  logic        o_idex_we;
  logic        o_idex_flush;
  logic        o_exmem_we;
  logic        o_exmem_flush;
  logic        o_md_start;
  logic [31:0] o_stall_cnt;
  logic [15:0] o_redir_cnt;
  logic [7:0]  ctl;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] model_stall = '0;
  logic [15:0] model_redir = '0;

  pipe_hazard_ctrl #(.CNT_W(32), .RCNT_W(16)) dut (
    .i_clk          (i_clk),
    .i_resetn       (i_resetn),
    .i_id_rs1       (i_id_rs1),
    .i_id_rs2       (i_id_rs2),
    .i_id_uses_rs1  (i_id_uses_rs1),
    .i_id_uses_rs2  (i_id_uses_rs2),
    .i_ex_rd        (i_ex_rd),
    .i_ex_memread   (i_ex_memread),
    .i_ex_redirect  (i_ex_redirect),
    .i_ex_is_muldiv (i_ex_is_muldiv),
    .i_md_done      (i_md_done),
    .i_imem_ready   (i_imem_ready),
    .i_dmem_ready   (i_dmem_ready),
    .o_pc_we        (o_pc_we),
    .o_ifid_we      (o_ifid_we),
    .o_ifid_flush   (o_ifid_flush),
    .o_idex_we      (o_idex_we),
    .o_idex_flush   (o_idex_flush),
    .o_exmem_we     (o_exmem_we),
    .o_exmem_flush  (o_exmem_flush),
    .o_md_start     (o_md_start),
    .o_stall_cnt    (o_stall_cnt),
    .o_redir_cnt    (o_redir_cnt)
  );

  assign ctl = {o_pc_we, o_ifid_we, o_ifid_flush, o_idex_we, o_idex_flush,
                o_exmem_we, o_exmem_flush, o_md_start};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic in_t idle();
    in_t v;
    v      = '0;
    v.imem = 1'b1;
    v.dmem = 1'b1;
    return v;
  endfunction

  task automatic drive_inputs(input in_t v);
    i_id_rs1       = v.rs1;
    i_id_rs2       = v.rs2;
    i_id_uses_rs1  = v.uses1;
    i_id_uses_rs2  = v.uses2;
    i_ex_rd        = v.rd;
    i_ex_memread   = v.memread;
    i_ex_redirect  = v.redirect;
    i_ex_is_muldiv = v.muldiv;
    i_md_done      = v.done;
    i_imem_ready   = v.imem;
    i_dmem_ready   = v.dmem;
  endtask

  // Drive one cycle at the falling edge and queue its expected controls.
  task automatic drive_cycle(input in_t v, input logic [7:0] e);
    @(negedge i_clk);
    i_resetn = 1'b1;
    drive_inputs(v);
    exp_q.push_back(e);
    #2;
  endtask

  // Advance the counter model by what the expected controls imply.
  task automatic account(input logic [7:0] e);
    if (!e[7]) model_stall = model_stall + 1;
    if ((e == RED) && (model_redir != 16'hFFFF)) model_redir = model_redir + 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] expv;
    i_resetn = 1'b0;
    drive_inputs(idle());
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    #2;
    exp_q.push_back(FRZ);
    expv = exp_q.pop_front();
    checks++;
    if (ctl !== expv) begin
      failures++;
      $display("[TB] FAIL reset_ctl got=%b expected=%b", ctl, expv);
    end
    checks++;
    if (o_stall_cnt !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_stall_cnt got=%0d expected=0", o_stall_cnt);
    end
    checks++;
    if (o_redir_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_redir_cnt got=%0d expected=0", o_redir_cnt);
    end
    drive_cycle(idle(), DEF);
    expv = exp_q.pop_front();
    checks++;
    if (ctl !== expv) begin
      failures++;
      $display("[TB] FAIL reset_release_ctl got=%b expected=%b", ctl, expv);
    end
    account(expv);
  endtask

  task automatic test_load_use();
    in_t        vin[5];
    logic [7:0] vexp[5];
    logic [7:0] expv;
    for (int i = 0; i < 5; i++) vin[i] = idle();
    vin[0].memread = 1; vin[0].rd = 5'd5; vin[0].rs2 = 5'd5; vin[0].uses2 = 1; vexp[0] = LU;
    vin[1].rd = 5'd5; vin[1].rs2 = 5'd5; vin[1].uses2 = 1;                     vexp[1] = DEF;
    vin[2].memread = 1; vin[2].uses2 = 1;                                      vexp[2] = DEF;
    vin[3].memread = 1; vin[3].rd = 5'd7; vin[3].rs1 = 5'd7; vin[3].rs2 = 5'd3;
    vin[3].uses2 = 1;                                                          vexp[3] = DEF;
    vin[4].memread = 1; vin[4].rd = 5'd7; vin[4].rs1 = 5'd7; vin[4].uses1 = 1; vexp[4] = LU;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(vin[i], vexp[i]);
      expv = exp_q.pop_front();
      checks++;
      if (ctl !== expv) begin
        failures++;
        $display("[TB] FAIL load_use[%0d] got=%b expected=%b", i, ctl, expv);
      end
      account(expv);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_stall_cnt !== model_stall) begin
      failures++;
      $display("[TB] FAIL load_use_stall_cnt got=%0d expected=%0d", o_stall_cnt, model_stall);
    end
  endtask

  task automatic test_redirect();
    in_t        vin[3];
    logic [7:0] vexp[3];
    logic [7:0] expv;
    for (int i = 0; i < 3; i++) vin[i] = idle();
    vin[0].redirect = 1; vin[0].memread = 1; vin[0].rd = 5'd5;
    vin[0].rs2 = 5'd5; vin[0].uses2 = 1;                      vexp[0] = RED;
    vin[1].redirect = 1; vin[1].imem = 0;                     vexp[1] = RED;
    vexp[2] = DEF;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(vin[i], vexp[i]);
      expv = exp_q.pop_front();
      checks++;
      if (ctl !== expv) begin
        failures++;
        $display("[TB] FAIL redirect[%0d] got=%b expected=%b", i, ctl, expv);
      end
      account(expv);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_redir_cnt !== model_redir) begin
      failures++;
      $display("[TB] FAIL redirect_cnt got=%0d expected=%0d", o_redir_cnt, model_redir);
    end
    checks++;
    if (o_stall_cnt !== model_stall) begin
      failures++;
      $display("[TB] FAIL redirect_stall_cnt got=%0d expected=%0d", o_stall_cnt, model_stall);
    end
  endtask

  task automatic test_imem_wait();
    in_t        vin[5];
    logic [7:0] vexp[5];
    logic [7:0] expv;
    for (int i = 0; i < 5; i++) vin[i] = idle();
    vin[0].imem = 0; vexp[0] = IMW;
    vin[1].imem = 0; vexp[1] = IMW;
    vin[2].imem = 0; vexp[2] = IMW;
    vexp[3] = DEF;
    vin[4].imem = 0; vin[4].memread = 1; vin[4].rd = 5'd9;
    vin[4].rs1 = 5'd9; vin[4].uses1 = 1; vexp[4] = LU;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(vin[i], vexp[i]);
      expv = exp_q.pop_front();
      checks++;
      if (ctl !== expv) begin
        failures++;
        $display("[TB] FAIL imem_wait[%0d] got=%b expected=%b", i, ctl, expv);
      end
      account(expv);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_stall_cnt !== model_stall) begin
      failures++;
      $display("[TB] FAIL imem_stall_cnt got=%0d expected=%0d", o_stall_cnt, model_stall);
    end
  endtask

  task automatic test_muldiv();
    in_t        vin[6];
    logic [7:0] vexp[6];
    logic [7:0] expv;
    logic [31:0] stall_before;
    stall_before = model_stall;
    for (int i = 0; i < 6; i++) vin[i] = idle();
    vin[0].muldiv = 1; vin[0].done = 1;     vexp[0] = MDS;
    vin[1].muldiv = 1;                      vexp[1] = MDB;
    vin[2].muldiv = 1; vin[2].redirect = 1; vexp[2] = MDB;
    vin[3].muldiv = 1;                      vexp[3] = MDB;
    vin[4].muldiv = 1; vin[4].done = 1;     vexp[4] = DEF;
    vexp[5] = DEF;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(vin[i], vexp[i]);
      expv = exp_q.pop_front();
      checks++;
      if (ctl !== expv) begin
        failures++;
        $display("[TB] FAIL muldiv[%0d] got=%b expected=%b", i, ctl, expv);
      end
      account(expv);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_stall_cnt !== stall_before + 32'd4) begin
      failures++;
      $display("[TB] FAIL muldiv_stall_cnt got=%0d expected=%0d", o_stall_cnt, stall_before + 32'd4);
    end
  endtask

  task automatic test_dmem_freeze();
    in_t        vin[10];
    logic [7:0] vexp[10];
    logic [7:0] expv;
    logic [15:0] redir_before;
    redir_before = model_redir;
    for (int i = 0; i < 10; i++) vin[i] = idle();
    vin[0].redirect = 1; vin[0].dmem = 0; vexp[0] = FRZ;
    vin[1].redirect = 1; vin[1].dmem = 0; vexp[1] = FRZ;
    vin[2].redirect = 1;                  vexp[2] = RED;
    vexp[3] = DEF;
    vin[4].muldiv = 1; vin[4].dmem = 0;   vexp[4] = FRZ;
    vin[5].muldiv = 1;                    vexp[5] = MDS;
    vin[6].muldiv = 1; vin[6].dmem = 0;   vexp[6] = FRZ;
    vin[7].muldiv = 1;                    vexp[7] = MDB;
    vin[8].muldiv = 1; vin[8].done = 1;   vexp[8] = DEF;
    vexp[9] = DEF;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(vin[i], vexp[i]);
      expv = exp_q.pop_front();
      checks++;
      if (ctl !== expv) begin
        failures++;
        $display("[TB] FAIL dmem_freeze[%0d] got=%b expected=%b", i, ctl, expv);
      end
      account(expv);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_redir_cnt !== redir_before + 16'd1) begin
      failures++;
      $display("[TB] FAIL dmem_redir_cnt got=%0d expected=%0d", o_redir_cnt, redir_before + 16'd1);
    end
    checks++;
    if (o_stall_cnt !== model_stall) begin
      failures++;
      $display("[TB] FAIL dmem_stall_cnt got=%0d expected=%0d", o_stall_cnt, model_stall);
    end
  endtask

  task automatic test_reset_mid_md();
    in_t        v;
    logic [7:0] expv;
    v = idle();
    v.muldiv = 1;
    drive_cycle(v, MDS);
    expv = exp_q.pop_front();
    checks++;
    if (ctl !== expv) begin
      failures++;
      $display("[TB] FAIL rst_md_start got=%b expected=%b", ctl, expv);
    end
    drive_cycle(v, MDB);
    expv = exp_q.pop_front();
    checks++;
    if (ctl !== expv) begin
      failures++;
      $display("[TB] FAIL rst_md_busy got=%b expected=%b", ctl, expv);
    end
    // Assert reset between clock edges while the unit is busy.
    @(posedge i_clk);
    #2;
    i_resetn = 1'b0;
    model_stall = '0;
    model_redir = '0;
    #1;
    exp_q.push_back(FRZ);
    expv = exp_q.pop_front();
    checks++;
    if (ctl !== expv) begin
      failures++;
      $display("[TB] FAIL rst_async_ctl got=%b expected=%b", ctl, expv);
    end
    checks++;
    if ((o_stall_cnt !== 32'd0) || (o_redir_cnt !== 16'd0)) begin
      failures++;
      $display("[TB] FAIL rst_async_cnt got=%0d/%0d expected=0/0", o_stall_cnt, o_redir_cnt);
    end
    @(posedge i_clk); #1;
    checks++;
    if (ctl !== 8'h00) begin
      failures++;
      $display("[TB] FAIL rst_hold_ctl got=%b expected=%b", ctl, 8'h00);
    end
    drive_cycle(v, MDS);
    expv = exp_q.pop_front();
    checks++;
    if (ctl !== expv) begin
      failures++;
      $display("[TB] FAIL rst_new_start got=%b expected=%b", ctl, expv);
    end
    account(expv);
    v.done = 1;
    drive_cycle(v, DEF);
    expv = exp_q.pop_front();
    checks++;
    if (ctl !== expv) begin
      failures++;
      $display("[TB] FAIL rst_new_done got=%b expected=%b", ctl, expv);
    end
    account(expv);
    drive_cycle(idle(), DEF);
    expv = exp_q.pop_front();
    account(expv);
    @(posedge i_clk); #1;
    checks++;
    if (o_stall_cnt !== model_stall) begin
      failures++;
      $display("[TB] FAIL rst_stall_cnt got=%0d expected=%0d", o_stall_cnt, model_stall);
    end
  endtask

  task automatic test_redir_saturate();
    in_t v;
    v = idle();
    v.redirect = 1;
    @(negedge i_clk);
    drive_inputs(v);
    while (model_redir != 16'hFFFE) begin
      @(posedge i_clk);
      model_redir = model_redir + 1'b1;
    end
    #1;
    checks++;
    if (o_redir_cnt !== 16'hFFFE) begin
      failures++;
      $display("[TB] FAIL sat_pre got=%h expected=%h", o_redir_cnt, 16'hFFFE);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_redir_cnt !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL sat_reach got=%h expected=%h", o_redir_cnt, 16'hFFFF);
    end
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (o_redir_cnt !== 16'hFFFF) begin
      failures++;
      $display("[TB] FAIL sat_hold got=%h expected=%h", o_redir_cnt, 16'hFFFF);
    end
    @(negedge i_clk);
    drive_inputs(idle());
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    i_resetn = 1'b0;
    drive_inputs(idle());
    test_reset();
    test_load_use();
    test_redirect();
    test_imem_wait();
    test_muldiv();
    test_dmem_freeze();
    test_reset_mid_md();
    test_redir_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
